// File: rtl/muldiv_unit_pkg.sv
// Shared MDU command codes and data types for the HI/LO multiply/divide unit.
package muldiv_unit_pkg;

   localparam int DATA_W = 32;

   typedef logic [DATA_W-1:0] word_t;

   typedef enum logic [2:0] {
      MULDIV_DO_MUL    = 3'd0,
      MULDIV_DO_MULU   = 3'd1,
      MULDIV_DO_DIV    = 3'd2,
      MULDIV_DO_DIVU   = 3'd3,
      MULDIV_SELECT_HI = 3'd4,
      MULDIV_SELECT_LO = 3'd5,
      MULDIV_NONE      = 3'd7
   } muldiv_sel_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// E-stage command bundle into the MDU and its busy/stall/readback return path.
interface muldiv_unit_if;
   import muldiv_unit_pkg::*;

   logic        start;
   logic        move_to;
   logic        move_from;
   muldiv_sel_e sel;
   word_t       a;
   word_t       b;
   logic        busy;
   logic        stall_req;
   word_t       out;

   modport master (
      output start, move_to, move_from, sel, a, b,
      input  busy, stall_req, out
   );

   modport slave (
      input  start, move_to, move_from, sel, a, b,
      output busy, stall_req, out
   );

endinterface

// File: rtl/muldiv_unit_compute.sv
// Combinational mult/multu/div/divu producing {hi,lo}; wr=0 for divide by zero or non-arith sel.
// Zero latency, no flow control.
module muldiv_unit_compute
   import muldiv_unit_pkg::*;
(
   input  muldiv_sel_e sel,
   input  word_t       a,
   input  word_t       b,
   output word_t       hi,
   output word_t       lo,
   output logic        wr
);

   logic [63:0] sprod;
   logic [63:0] uprod;
   logic        is_signed;
   word_t       dividend;
   word_t       divisor;
   word_t       quot;
   word_t       rem;

   always_comb begin
      sprod     = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      uprod     = {32'b0, a} * {32'b0, b};
      is_signed = (sel == MULDIV_DO_DIV);
      // Signed divide works on magnitudes, then restores signs; this also wraps
      // 0x80000000 / -1 to 0x80000000 instead of trapping.
      dividend  = (is_signed && a[31]) ? -a : a;
      divisor   = (is_signed && b[31]) ? -b : b;
      if (divisor == '0) divisor = 32'd1;
      quot      = dividend / divisor;
      rem       = dividend % divisor;

      hi = '0;
      lo = '0;
      wr = 1'b0;
      case (sel)
         MULDIV_DO_MUL: begin
            {hi, lo} = sprod;
            wr       = 1'b1;
         end
         MULDIV_DO_MULU: begin
            {hi, lo} = uprod;
            wr       = 1'b1;
         end
         MULDIV_DO_DIV, MULDIV_DO_DIVU: begin
            lo = (is_signed && (a[31] ^ b[31])) ? -quot : quot;
            hi = (is_signed && a[31]) ? -rem : rem;
            wr = (b != '0);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: result commits MUL_CYCLES/DIV_CYCLES edges after start, mthi/mtlo in one edge.
// Any MDU command presented while busy raises stall_req and is ignored until busy drops.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input logic          clk,
   input logic          reset,
   muldiv_unit_if.slave mdu
);

   localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   logic [CNT_W-1:0] cnt;
   word_t            hi;
   word_t            lo;
   word_t            pend_hi;
   word_t            pend_lo;
   logic             pend_wr;
   word_t            calc_hi;
   word_t            calc_lo;
   logic             calc_wr;
   logic             is_mul;
   logic             is_div;

   muldiv_unit_compute u_compute (
      .sel (mdu.sel),
      .a   (mdu.a),
      .b   (mdu.b),
      .hi  (calc_hi),
      .lo  (calc_lo),
      .wr  (calc_wr)
   );

   assign is_mul        = (mdu.sel == MULDIV_DO_MUL) || (mdu.sel == MULDIV_DO_MULU);
   assign is_div        = (mdu.sel == MULDIV_DO_DIV) || (mdu.sel == MULDIV_DO_DIVU);
   assign mdu.busy      = (cnt != '0);
   assign mdu.stall_req = mdu.busy && (mdu.start || mdu.move_to || mdu.move_from);
   assign mdu.out       = (mdu.sel == MULDIV_SELECT_HI) ? hi : lo;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         hi      <= '0;
         lo      <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_wr <= 1'b0;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1) && pend_wr) begin
            hi <= pend_hi;
            lo <= pend_lo;
         end
      end else if (mdu.start) begin
         // start has priority: a coincident move_to is dropped
         if (is_mul || is_div) begin
            cnt     <= is_mul ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
            pend_hi <= calc_hi;
            pend_lo <= calc_lo;
            pend_wr <= calc_wr;
         end
      end else if (mdu.move_to) begin
         if (mdu.sel == MULDIV_SELECT_HI) hi <= mdu.a;
         else if (mdu.sel == MULDIV_SELECT_LO) lo <= mdu.a;
      end
   end

`ifndef SYNTHESIS
   assert property (@(posedge clk) disable iff (reset) !(mdu.start && mdu.move_to));
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, multi-cycle corner sequences, random ops vs model.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   localparam int MULC = 5;
   localparam int DIVC = 10;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   muldiv_unit_if mdu ();

   muldiv_unit #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
      .clk   (clk),
      .reset (reset),
      .mdu   (mdu.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      muldiv_sel_e op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pre_hi;
      logic [31:0] pre_lo;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          exp_busy;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      mdu.start     = 1'b0;
      mdu.move_to   = 1'b0;
      mdu.move_from = 1'b0;
      mdu.sel       = MULDIV_NONE;
      mdu.a         = '0;
      mdu.b         = '0;
   endtask

   // Reference arithmetic straight from the ISA definition using 64-bit integers.
   function automatic void ref_op(input muldiv_sel_e op, input logic [31:0] x, input logic [31:0] y,
                                  input logic [31:0] old_h, input logic [31:0] old_l,
                                  output logic [31:0] h, output logic [31:0] l);
      longint sx;
      longint sy;
      longint unsigned ux;
      longint unsigned uy;
      longint q;
      longint r;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'b0, x};
      uy = {32'b0, y};
      h  = old_h;
      l  = old_l;
      case (op)
         MULDIV_DO_MUL:  begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
         MULDIV_DO_MULU: begin p = ux * uy; h = p[63:32]; l = p[31:0]; end
         MULDIV_DO_DIV:  if (y != 0) begin q = sx / sy; r = sx % sy; l = q[31:0]; h = r[31:0]; end
         MULDIV_DO_DIVU: if (y != 0) begin l = x / y; h = x % y; end
         default: ;
      endcase
   endfunction

   task automatic write_reg(input muldiv_sel_e s, input logic [31:0] v);
      mdu.sel     = s;
      mdu.a       = v;
      mdu.move_to = 1'b1;
      tick();
      idle();
   endtask

   task automatic read_reg(input muldiv_sel_e s, output logic [31:0] v);
      mdu.sel       = s;
      mdu.move_from = 1'b1;
      #1;
      v = mdu.out;
      chk("read_no_stall", {31'b0, mdu.stall_req}, 32'd0);
      idle();
      #1;
   endtask

   task automatic run_op(input muldiv_sel_e op, input logic [31:0] x, input logic [31:0] y, output int n);
      mdu.sel   = op;
      mdu.a     = x;
      mdu.b     = y;
      mdu.start = 1'b1;
      tick();
      idle();
      n = 0;
      while (mdu.busy && n < 40) begin
         n++;
         tick();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] v;
      logic [31:0] eh;
      logic [31:0] el;
      int n;
      muldiv_sel_e op;

      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      idle();

      vecs[0] = '{"mult",     MULDIV_DO_MUL,  32'hFFFFFFFF, 32'd2,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFE, MULC};
      vecs[1] = '{"multu",    MULDIV_DO_MULU, 32'hFFFFFFFF, 32'd2,        32'h0,  32'h0,  32'h00000001, 32'hFFFFFFFE, MULC};
      vecs[2] = '{"div_neg",  MULDIV_DO_DIV,  32'hFFFFFFF9, 32'd2,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFD, DIVC};
      vecs[3] = '{"divu",     MULDIV_DO_DIVU, 32'd7,        32'd2,        32'h0,  32'h0,  32'd1,        32'd3,        DIVC};
      vecs[4] = '{"div_ovf",  MULDIV_DO_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h5,  32'h6,  32'h0,        32'h80000000, DIVC};
      vecs[5] = '{"divu_by0", MULDIV_DO_DIVU, 32'd7,        32'd0,        32'h11, 32'h22, 32'h11,       32'h22,       DIVC};

      // Reset state
      mdu.sel = MULDIV_SELECT_HI;
      #3;
      chk("rst_busy",  {31'b0, mdu.busy}, 32'd0);
      chk("rst_stall", {31'b0, mdu.stall_req}, 32'd0);
      chk("rst_out",   mdu.out, 32'd0);
      tick();
      tick();
      reset = 1'b0;
      idle();
      m_hi = '0;
      m_lo = '0;

      // Directed vector table
      foreach (vecs[i]) begin
         write_reg(MULDIV_SELECT_HI, vecs[i].pre_hi);
         write_reg(MULDIV_SELECT_LO, vecs[i].pre_lo);
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
         chk({vecs[i].name, "_busy_cycles"}, 32'(n), 32'(vecs[i].exp_busy));
         read_reg(MULDIV_SELECT_HI, v);
         chk({vecs[i].name, "_hi"}, v, vecs[i].exp_hi);
         read_reg(MULDIV_SELECT_LO, v);
         chk({vecs[i].name, "_lo"}, v, vecs[i].exp_lo);
      end

      // mfhi/mflo held behind a multu: stalls for the whole busy window
      mdu.sel = MULDIV_DO_MULU; mdu.a = 32'd3; mdu.b = 32'd4; mdu.start = 1'b1;
      tick();
      idle();
      mdu.sel = MULDIV_SELECT_LO;
      mdu.move_from = 1'b1;
      #1;
      n = 0;
      while (mdu.stall_req && n < 40) begin
         n++;
         @(posedge clk);
         #2;
      end
      chk("hazard_stall_cycles", 32'(n), 32'(MULC));
      chk("hazard_out", mdu.out, 32'h0000000C);
      chk("hazard_busy_after", {31'b0, mdu.busy}, 32'd0);
      idle();
      tick();

      // A start re-presented while busy must not restart or replace the op
      mdu.sel = MULDIV_DO_MUL; mdu.a = 32'd5; mdu.b = 32'd6; mdu.start = 1'b1;
      tick();
      n = 0;
      mdu.sel = MULDIV_DO_DIV; mdu.a = 32'd100; mdu.b = 32'd3;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk("restart_stall", {31'b0, mdu.stall_req}, 32'd1);
         if (mdu.busy) n++;
         tick();
      end
      idle();
      while (mdu.busy && n < 40) begin
         n++;
         tick();
      end
      chk("restart_busy_cycles", 32'(n), 32'(MULC));
      read_reg(MULDIV_SELECT_HI, v);
      chk("restart_hi", v, 32'd0);
      read_reg(MULDIV_SELECT_LO, v);
      chk("restart_lo", v, 32'd30);

      // Back-to-back mthi/mtlo: immediate, no busy, no stall
      mdu.sel = MULDIV_SELECT_HI; mdu.a = 32'hDEADBEEF; mdu.move_to = 1'b1;
      tick();
      mdu.sel = MULDIV_SELECT_LO; mdu.a = 32'h12345678;
      #1;
      chk("mt_busy",  {31'b0, mdu.busy}, 32'd0);
      chk("mt_stall", {31'b0, mdu.stall_req}, 32'd0);
      tick();
      idle();
      read_reg(MULDIV_SELECT_HI, v);
      chk("mthi_val", v, 32'hDEADBEEF);
      read_reg(MULDIV_SELECT_LO, v);
      chk("mtlo_val", v, 32'h12345678);

      // Unlisted sel with start / move_to: no-op
      mdu.sel = MULDIV_SELECT_HI; mdu.a = 32'h99999999; mdu.start = 1'b1;
      tick();
      idle();
      chk("badsel_start_busy", {31'b0, mdu.busy}, 32'd0);
      mdu.sel = MULDIV_DO_MUL; mdu.a = 32'h77777777; mdu.move_to = 1'b1;
      tick();
      idle();
      read_reg(MULDIV_SELECT_HI, v);
      chk("badsel_hi", v, 32'hDEADBEEF);
      read_reg(MULDIV_SELECT_LO, v);
      chk("badsel_lo", v, 32'h12345678);

      // Reset three cycles into a div: clears immediately, pending result is lost
      write_reg(MULDIV_SELECT_HI, 32'h55);
      write_reg(MULDIV_SELECT_LO, 32'h66);
      mdu.sel = MULDIV_DO_DIV; mdu.a = 32'd100; mdu.b = 32'd7; mdu.start = 1'b1;
      tick();
      idle();
      tick();
      tick();
      reset = 1'b1;
      mdu.sel = MULDIV_SELECT_HI;
      mdu.move_from = 1'b1;
      #1;
      chk("midrst_busy",  {31'b0, mdu.busy}, 32'd0);
      chk("midrst_stall", {31'b0, mdu.stall_req}, 32'd0);
      chk("midrst_hi",    mdu.out, 32'd0);
      mdu.sel = MULDIV_SELECT_LO;
      #1;
      chk("midrst_lo",    mdu.out, 32'd0);
      idle();
      tick();
      tick();
      reset = 1'b0;
      for (int c = 0; c < 15; c++) tick();
      chk("postrst_busy", {31'b0, mdu.busy}, 32'd0);
      read_reg(MULDIV_SELECT_HI, v);
      chk("postrst_hi", v, 32'd0);
      read_reg(MULDIV_SELECT_LO, v);
      chk("postrst_lo", v, 32'd0);
      write_reg(MULDIV_SELECT_HI, 32'hABCD1234);
      read_reg(MULDIV_SELECT_HI, v);
      chk("postrst_mthi", v, 32'hABCD1234);
      m_hi = 32'hABCD1234;
      m_lo = 32'd0;

      // Randomized ops against the reference model
      for (int it = 0; it < 40; it++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'd0;
            1:       rb = $urandom_range(1, 9);
            2:       rb = -($urandom_range(1, 9));
            default: rb = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: op = MULDIV_DO_MUL;
            1: op = MULDIV_DO_MULU;
            2: op = MULDIV_DO_DIV;
            3: op = MULDIV_DO_DIVU;
            4: op = MULDIV_SELECT_HI;
            default: op = MULDIV_SELECT_LO;
         endcase
         if (op == MULDIV_SELECT_HI) begin
            write_reg(op, ra);
            m_hi = ra;
         end else if (op == MULDIV_SELECT_LO) begin
            write_reg(op, ra);
            m_lo = ra;
         end else begin
            ref_op(op, ra, rb, m_hi, m_lo, eh, el);
            m_hi = eh;
            m_lo = el;
            run_op(op, ra, rb, n);
            chk("rand_busy_cycles", 32'(n),
                32'((op == MULDIV_DO_MUL || op == MULDIV_DO_MULU) ? MULC : DIVC));
         end
         read_reg(MULDIV_SELECT_HI, v);
         chk("rand_hi", v, m_hi);
         read_reg(MULDIV_SELECT_LO, v);
         chk("rand_lo", v, m_lo);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide resource (HI/LO pair) in the E stage of the 5-stage pipeline.
- Executes the decoder's StartMDU / MoveToMDU / MoveFromMDU / MDUSel commands with a fixed-latency busy counter.
- Drives the HI/LO read value for mfhi/mflo.
- Raises a stall request so the hazard unit freezes D/E while an MDU instruction meets a busy unit.

Parameters:
MUL_CYCLES, 5, busy duration for mult/multu (must be >= 1)
DIV_CYCLES, 10, busy duration for div/divu (must be >= 1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  E-stage instruction is mult/multu/div/divu (StartMDU)
move_to  in  1  E-stage instruction is mthi/mtlo (MoveToMDU)
move_from  in  1  E-stage instruction is mfhi/mflo (MoveFromMDU)
sel  in  3  MDUSel code from decoder
a  in  32  forwarded rs value
b  in  32  forwarded rt value
busy  out  1  operation in flight
stall_req  out  1  E-stage MDU instruction must be held this cycle
out  out  32  HI if sel==SELECT_HI, else LO (combinational from committed regs)

Behaviour:
- Reset (async, any time including mid-operation):
  - hi, lo, cnt cleared to 0; busy=0; pending result discarded.
  - out=0 and stall_req=0 while reset is held.
- stall_req is combinational: busy && (start || move_to || move_from).
- A command is accepted only when busy==0. While stalled, the pipeline re-presents the same command each cycle.
- Accepting start=1 at edge k:
  - sel is one of DO_MUL/DO_MULU/DO_DIV/DO_DIVU.
  - Compute the result from a/b and latch it into pend_hi/pend_lo.
  - Load cnt with MUL_CYCLES or DIV_CYCLES.
  - busy=1 from after edge k through edge k+N-1.
  - At edge k+N: hi<=pend_hi, lo<=pend_lo, busy falls.
  - busy is therefore high for exactly N cycles.
  - An mfhi/mflo issued right after start sees busy=1, stalls N cycles, then reads the new value.
- Arithmetic:
  - mult: signed 32x32->64, HI=upper, LO=lower.
  - multu: same, unsigned.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
  - Divide by zero: busy sequence still runs for DIV_CYCLES; hi/lo left unchanged at completion.
- move_to accepted at edge k: sel==SELECT_HI writes hi<=a, sel==SELECT_LO writes lo<=a. Value is visible on out in cycle k+1 with no busy period.
- move_from: no state change; only affects stall_req.
- Simultaneous events:
  - start and move_to together: start wins, move_to dropped. Not produced by the decoder; assertion only.
  - Any unlisted sel with start or move_to: no-op.
  - Completion edge coincident with a new command: cannot occur, because busy is still 1 at that edge and the command is stalled. The command is accepted on the next edge.
- cnt width: $clog2(max(MUL_CYCLES, DIV_CYCLES)+1). cnt decrements each cycle while nonzero.

Decomposition:
- const.v holds the shared constants: MULDIV_DO_MUL=3'd0, MULDIV_DO_MULU=3'd1, MULDIV_DO_DIV=3'd2, MULDIV_DO_DIVU=3'd3, MULDIV_SELECT_HI=3'd4, MULDIV_SELECT_LO=3'd5. Code 3'd7 means none.
- Sub-module muldiv_compute: pure combinational {hi,lo} from op/a/b, including the div-by-zero flag.
- The muldiv_unit top holds the counter, pending registers, HI/LO and stall logic.

Test Plan:
- Reset mid-op:
  - Pulse reset 3 cycles into a div.
  - Expected: busy=0, hi=lo=0 immediately; no later write; next mthi accepted.
- mult a=0xFFFFFFFF, b=2:
  - Expected: busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - Same operands with multu: HI=0x00000001, LO=0xFFFFFFFE.
- div a=0xFFFFFFF9 (-7), b=2:
  - Expected: busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7/2: LO=3, HI=1.
- Overflow and divide by zero:
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu 7/0 with hi=0x11, lo=0x22: busy 10 cycles, hi/lo remain 0x11/0x22.
- Back-to-back hazard:
  - multu 3*4, then mflo held with move_from=1.
  - Expected: stall_req=1 for 5 cycles, 0 in the following cycle with out=0x0000000C.
  - A second start while busy is not accepted: busy count is not restarted.
- mthi a=0xDEADBEEF, then mtlo a=0x12345678 on consecutive edges:
  - Expected: out(sel=HI)=0xDEADBEEF, out(sel=LO)=0x12345678.
  - No busy and no stall.
